// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART (TXD/RXD/CON at 0x40000018..0x40000020) with a registered level IRQ.
// The TX and RX bit engines are two-process FSMs that share one bit-timing scheme.
module uart_mmio #(
   parameter int unsigned BAUD_DIV = 10416
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] Address,
   input  logic [31:0] Write_data,
   output logic [31:0] Read_data,
   input  logic        uart_rx,
   output logic        uart_tx,
   output logic        irq_out
);
   localparam int unsigned   CW       = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(BAUD_DIV / 2 - 1);
   localparam logic [31:0]   ADDR_TXD = 32'h4000_0018;
   localparam logic [31:0]   ADDR_RXD = 32'h4000_001C;
   localparam logic [31:0]   ADDR_CON = 32'h4000_0020;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

   uart_state_e tx_state_q, tx_state_d, rx_state_q, rx_state_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
   logic [2:0]    tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
   logic [7:0]    tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
   logic [7:0]    tx_byte_q, tx_byte_d, rx_data_q, rx_data_d;
   logic          tx_start_q, tx_start_d, tx_line_q, tx_line_d;
   logic          rx_s1_q, rx_s2_q;
   logic          tx_irq_en_q, tx_irq_en_d, rx_irq_en_q, rx_irq_en_d;
   logic          tx_done_q, tx_done_d, rx_valid_q, rx_valid_d;
   logic          rx_overrun_q, rx_overrun_d, irq_q, irq_d;
   logic          tx_done_set, rx_set, tx_busy;
   logic          sel_txd, sel_rxd, sel_con, wdata_unused;

   assign sel_txd      = (Address == ADDR_TXD);
   assign sel_rxd      = (Address == ADDR_RXD);
   assign sel_con      = (Address == ADDR_CON);
   assign tx_busy      = (tx_state_q != S_IDLE);
   assign wdata_unused = ^Write_data[31:8];
   assign uart_tx      = tx_line_q;
   assign irq_out      = irq_q;

   // A write is latched at edge N and the start bit goes out at edge N+1.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
      tx_state_d  = tx_state_q;
      tx_cnt_d    = tx_cnt_q;
      tx_bit_d    = tx_bit_q;
      tx_shift_d  = tx_shift_q;
      tx_byte_d   = tx_byte_q;
      tx_start_d  = 1'b0;
      tx_done_set = 1'b0;
      case (tx_state_q)
         S_IDLE: begin
            if (tx_start_q) begin
               tx_state_d = S_START;
               tx_cnt_d   = '0;
            end else if (MemWrite && sel_txd) begin
               tx_start_d = 1'b1;
               tx_byte_d  = Write_data[7:0];
               tx_shift_d = Write_data[7:0];
            end
         end
         S_START: begin
            if (tx_cnt_q == CNT_LAST) begin
               tx_state_d = S_DATA;
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
            end else tx_cnt_d = tx_cnt_q + 1'b1;
         end
         S_DATA: begin
            if (tx_cnt_q == CNT_LAST) begin
               tx_cnt_d = '0;
               if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
               else begin
                  tx_bit_d   = tx_bit_q + 1'b1;
                  tx_shift_d = {1'b0, tx_shift_q[7:1]};
               end
            end else tx_cnt_d = tx_cnt_q + 1'b1;
         end
         default: begin
            if (tx_cnt_q == CNT_LAST) begin
               tx_state_d  = S_IDLE;
               tx_cnt_d    = '0;
               tx_done_set = 1'b1;
            end else tx_cnt_d = tx_cnt_q + 1'b1;
         end
      endcase
      tx_line_d = 1'b1;
      if (tx_state_d == S_START)     tx_line_d = 1'b0;
      else if (tx_state_d == S_DATA) tx_line_d = tx_shift_d[0];
   end

   // Start bit is re-checked at mid-bit; every later sample lands mid-bit as well.
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_data_d  = rx_data_q;
      rx_set     = 1'b0;
      case (rx_state_q)
         S_IDLE: begin
            if (!rx_s2_q) begin
               rx_state_d = S_START;
               rx_cnt_d   = '0;
            end
         end
         S_START: begin
            if (rx_cnt_q == CNT_HALF) begin
               rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
            end else rx_cnt_d = rx_cnt_q + 1'b1;
         end
         S_DATA: begin
            if (rx_cnt_q == CNT_LAST) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
               if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
               else                  rx_bit_d   = rx_bit_q + 1'b1;
            end else rx_cnt_d = rx_cnt_q + 1'b1;
         end
         default: begin
            if (rx_cnt_q == CNT_LAST) begin
               rx_state_d = S_IDLE;
               rx_cnt_d   = '0;
               if (rx_s2_q) begin
                  rx_set    = 1'b1;
                  rx_data_d = rx_shift_q;
               end
            end else rx_cnt_d = rx_cnt_q + 1'b1;
         end
      endcase
   end

   // Flag sets take priority over read-clears on the same edge.
   always_comb begin
      tx_irq_en_d  = tx_irq_en_q;
      rx_irq_en_d  = rx_irq_en_q;
      if (MemWrite && sel_con) {rx_irq_en_d, tx_irq_en_d} = Write_data[1:0];
      tx_done_d    = tx_done_set | (tx_done_q & ~(MemRead & sel_con));
      rx_valid_d   = rx_set | (rx_valid_q & ~(MemRead & sel_rxd));
      rx_overrun_d = (rx_set & rx_valid_q) | (rx_overrun_q & ~(MemRead & sel_con));
      irq_d        = (tx_irq_en_q & tx_done_q) | (rx_irq_en_q & rx_valid_q);
   end

   always_comb begin
      Read_data = '0;
      if (MemRead) begin
         if (sel_txd)      Read_data = {24'b0, tx_byte_q};
         else if (sel_rxd) Read_data = {24'b0, rx_data_q};
         else if (sel_con) Read_data = {26'b0, rx_overrun_q, tx_busy, rx_valid_q,
                                        tx_done_q, rx_irq_en_q, tx_irq_en_q};
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!reset) begin
         tx_state_q <= S_IDLE;     rx_state_q <= S_IDLE;
         tx_cnt_q   <= '0;         rx_cnt_q   <= '0;
         tx_bit_q   <= '0;         rx_bit_q   <= '0;
         tx_shift_q <= '0;         rx_shift_q <= '0;
         tx_byte_q  <= '0;         rx_data_q  <= '0;
         tx_start_q <= 1'b0;       tx_line_q  <= 1'b1;
         rx_s1_q    <= 1'b1;       rx_s2_q    <= 1'b1;
         tx_irq_en_q <= 1'b0;      rx_irq_en_q <= 1'b0;
         tx_done_q  <= 1'b0;       rx_valid_q <= 1'b0;
         rx_overrun_q <= 1'b0;     irq_q      <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d; rx_state_q <= rx_state_d;
         tx_cnt_q   <= tx_cnt_d;   rx_cnt_q   <= rx_cnt_d;
         tx_bit_q   <= tx_bit_d;   rx_bit_q   <= rx_bit_d;
         tx_shift_q <= tx_shift_d; rx_shift_q <= rx_shift_d;
         tx_byte_q  <= tx_byte_d;  rx_data_q  <= rx_data_d;
         tx_start_q <= tx_start_d; tx_line_q  <= tx_line_d;
         rx_s1_q    <= uart_rx;    rx_s2_q    <= rx_s1_q;
         tx_irq_en_q <= tx_irq_en_d; rx_irq_en_q <= rx_irq_en_d;
         tx_done_q  <= tx_done_d;  rx_valid_q <= rx_valid_d;
         rx_overrun_q <= rx_overrun_d; irq_q  <= irq_d;
      end
   end
endmodule

// File: tb/tb_uart_mmio.sv
// Bench for uart_mmio at BAUD_DIV=16: reads and TX frames are scored by monitors against expectation queues
// filled when the stimulus is issued; IRQ and line timing are checked inline.
module tb_uart_mmio;
   localparam logic [31:0] TXD = 32'h4000_0018;
   localparam logic [31:0] RXD = 32'h4000_001C;
   localparam logic [31:0] CON = 32'h4000_0020;

   logic        clk = 1'b0;
   logic        reset, MemRead, MemWrite, uart_rx, uart_tx, irq_out;
   logic [31:0] Address, Write_data, Read_data;

   int total = 0;
   int bad   = 0;

   string       rd_name_q[$];
   logic [31:0] rd_val_q[$];
   logic [7:0]  tx_exp_q[$];

   uart_mmio #(.BAUD_DIV(16)) dut (
      .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
      .Address(Address), .Write_data(Write_data), .Read_data(Read_data),
      .uart_rx(uart_rx), .uart_tx(uart_tx), .irq_out(irq_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Each helper starts 1ns after a rising edge and returns 1ns after the next one.
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_read(input string name, input logic [31:0] addr, input logic [31:0] exp);
      rd_name_q.push_back(name);
      rd_val_q.push_back(exp);
      MemRead = 1'b1;
      Address = addr;
      cyc(1);
      MemRead = 1'b0;
   endtask

   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
      MemWrite   = 1'b1;
      Address    = addr;
      Write_data = data;
      cyc(1);
      MemWrite   = 1'b0;
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop, input int stop_cycles);
      uart_rx = 1'b0;
      cyc(16);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         cyc(16);
      end
      uart_rx = stop;
      cyc(stop_cycles);
      uart_rx = 1'b1;
   endtask

   // Read monitor: whenever a read strobe is on the bus, score Read_data against the queue head.
   always @(negedge clk) begin
      if (MemRead === 1'b1) begin
         check("rd_expected_avail", 32'(rd_name_q.size() != 0), 32'd1);
         if (rd_name_q.size() != 0) check(rd_name_q.pop_front(), Read_data, rd_val_q.pop_front());
      end
   end

   // TX monitor: decode each frame by mid-bit sampling and score it against the queue head.
   initial begin : tx_mon
      logic [7:0] b;
      forever begin
         @(negedge uart_tx);
         repeat (8) @(negedge clk);
         check("tx_start_bit", 32'(uart_tx), 32'd0);
         for (int i = 0; i < 8; i++) begin
            repeat (16) @(negedge clk);
            b[i] = uart_tx;
         end
         repeat (16) @(negedge clk);
         check("tx_stop_bit", 32'(uart_tx), 32'd1);
         check("tx_expected_avail", 32'(tx_exp_q.size() != 0), 32'd1);
         if (tx_exp_q.size() != 0) check("tx_frame", 32'(b), 32'(tx_exp_q.pop_front()));
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
      Address = TXD; Write_data = '0; uart_rx = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_uart_tx", 32'(uart_tx), 32'd1);
      check("rst_irq", 32'(irq_out), 32'd0);
      check("rst_rdata_no_strobe", Read_data, 32'd0);
      reset = 1'b1;
      cyc(2);
      bus_read("rst_con", CON, 32'h00);
      bus_read("rst_txd", TXD, 32'h00);
      bus_read("rst_rxd", RXD, 32'h00);

      // CON writes only reach the two enables.
      bus_write(CON, 32'hFF);
      bus_read("con_wr_mask", CON, 32'h03);
      bus_write(CON, 32'h01);

      // TX 0xA5 accepted at edge N; a second write at N+20 must be dropped.
      bus_write(TXD, 32'hA5);
      tx_exp_q.push_back(8'hA5);
      check("tx_line_at_N", 32'(uart_tx), 32'd1);
      cyc(1);
      check("tx_line_at_N1", 32'(uart_tx), 32'd0);
      cyc(18);
      bus_write(TXD, 32'h3C);
      cyc(140);
      bus_read("con_busy_N160", CON, 32'h11);
      check("irq_N161", 32'(irq_out), 32'd0);
      bus_read("con_done_set_wins", CON, 32'h05);
      check("irq_N162", 32'(irq_out), 32'd1);
      bus_read("con_done_cleared", CON, 32'h01);
      check("irq_N163", 32'(irq_out), 32'd0);
      bus_read("txd_after_drop", TXD, 32'hA5);

      // RX 0x5A with rx interrupt enabled; rx_valid sets at E+155.
      bus_write(CON, 32'h02);
      send_rx(8'h5A, 1'b1, 10);
      check("irq_before_valid", 32'(irq_out), 32'd0);
      cyc(1);
      check("irq_valid_edge", 32'(irq_out), 32'd0);
      bus_read("con_rx_valid", CON, 32'h0A);
      check("irq_rx_set", 32'(irq_out), 32'd1);
      cyc(6);
      bus_read("rxd_5a", RXD, 32'h5A);
      check("irq_after_read", 32'(irq_out), 32'd1);
      cyc(1);
      check("irq_cleared", 32'(irq_out), 32'd0);
      bus_read("con_after_rxd", CON, 32'h02);

      // Overrun: two frames without a read.
      send_rx(8'h11, 1'b1, 16);
      send_rx(8'h22, 1'b1, 16);
      bus_read("con_overrun", CON, 32'h2A);
      bus_read("con_overrun_clr", CON, 32'h0A);
      bus_read("rxd_22", RXD, 32'h22);
      bus_read("con_rx_clr", CON, 32'h02);

      // Framing error: stop bit low leaves data and flags alone.
      send_rx(8'h33, 1'b0, 16);
      cyc(20);
      bus_read("con_framing", CON, 32'h02);
      bus_read("rxd_framing", RXD, 32'h22);

      // Short low glitch is a false start.
      uart_rx = 1'b0;
      cyc(4);
      uart_rx = 1'b1;
      cyc(30);
      bus_read("con_glitch", CON, 32'h02);
      bus_read("rxd_glitch", RXD, 32'h22);

      // Unmatched addresses.
      bus_read("rd_unmapped", 32'h4000_0024, 32'h00);
      bus_write(32'h4000_0014, 32'hFF);
      bus_read("con_after_bad_wr", CON, 32'h02);
      bus_read("txd_after_bad_wr", TXD, 32'hA5);
      bus_read("rxd_after_bad_wr", RXD, 32'h22);

      // Reset at bit 4 of a 0x81 frame: bits 0..3 go out as 1,0,0,0, the rest reads as idle-high.
      bus_write(TXD, 32'h81);
      tx_exp_q.push_back(8'hF1);
      cyc(81);
      reset = 1'b0;
      cyc(1);
      reset = 1'b1;
      check("tx_line_after_reset", 32'(uart_tx), 32'd1);
      cyc(100);
      bus_read("con_after_reset", CON, 32'h00);
      bus_read("txd_after_reset", TXD, 32'h00);
      bus_write(TXD, 32'hC3);
      tx_exp_q.push_back(8'hC3);
      cyc(170);
      bus_read("con_fresh_done", CON, 32'h04);
      bus_read("txd_fresh", TXD, 32'hC3);

      cyc(2);
      check("rd_queue_drained", 32'(rd_name_q.size()), 32'd0);
      check("tx_queue_drained", 32'(tx_exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uart_mmio.md
# uart_mmio

Memory-mapped UART responder that sits on the CPU data bus beside data memory, serving the `0x4xxxxxxx` peripheral window. It answers the CPU's single-cycle `MemRead`/`MemWrite` accesses and converts register writes into 8N1 serial frames on `uart_tx`. It deserializes frames arriving on `uart_rx` into a readable register. A level interrupt feeds the CPU's IRQ input.

## Interface
- `BAUD_DIV`, 10416: clock cycles per bit (100 MHz / 9600); legal range 4..65535.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `MemRead`  in  1  CPU read strobe, valid for one cycle with `Address`.
- `MemWrite`  in  1  CPU write strobe.
- `Address`  in  32  byte address; full 32-bit exact decode.
- `Write_data`  in  32  write data; only `[7:0]` used.
- `Read_data`  out  32  combinational read data.
- `uart_rx`  in  1  asynchronous serial input, idle high.
- `uart_tx`  out  1  serial output, idle high.
- `irq_out`  out  1  level interrupt request.

## Operation
- Register map:
  - `0x40000018` TXD, RW: a write loads `[7:0]` and starts a frame. A read returns `{24'b0, last accepted byte}`.
  - `0x4000001C` RXD, RO: a read returns `{24'b0, rx_data}` and clears `rx_valid`.
  - `0x40000020` CON:
    - `[0]` tx_irq_en and `[1]` rx_irq_en are RW.
    - `[2]` tx_done is sticky and cleared by a CON read.
    - `[3]` rx_valid is RO.
    - `[4]` tx_busy is RO.
    - `[5]` rx_overrun is sticky and cleared by a CON read.
    - Writes affect `[1:0]` only.
- `Read_data` = 0 when `MemRead`=0 or the address is unmatched. Writes to unmatched addresses are ignored.
- Read side effects (clears) commit on the clock edge where `MemRead`=1 and the address matches.
- `irq_out` = (tx_irq_en & tx_done) | (rx_irq_en & rx_valid), registered.
- TX state machine, IDLE → START → DATA(8, LSB first) → STOP → IDLE:
  - Each state holds one bit for `BAUD_DIV` cycles. Line levels: START=0, STOP=1.
  - A TXD write while not IDLE is dropped: data not latched, no flag change.
  - Leaving STOP sets tx_done.
- RX path: `uart_rx` passes through a 2-flop synchronizer. RX state machine, IDLE → START → DATA → STOP:
  - IDLE: a synchronized low level moves to START.
  - START: sample after `BAUD_DIV/2` cycles. If the sample is high, it is a false start → IDLE.
  - DATA: sample every `BAUD_DIV` cycles for 8 bits, LSB first.
  - STOP: sample once. If 1: load rx_data and set rx_valid; if rx_valid was already 1, also set rx_overrun (new byte overwrites). If 0 (framing error): discard the byte with no flag change. Return to IDLE either way.
- Simultaneous set and read-clear of the same flag in one cycle: set wins.

## Timing
- Reset values:
  - `uart_tx`=1, `Read_data`=0 (no strobe), `irq_out`=0.
  - All flags and enables 0, rx_data=0, last TX byte 0.
  - Both state machines IDLE, counters 0.
- Reset asserted mid-frame aborts it at the next edge: `uart_tx`=1 and no flags set.
- TXD write accepted at edge N: `uart_tx` falls at edge N+1. tx_busy=1 from N+1 through the end of STOP.
- tx_done sets at edge N+1+10·`BAUD_DIV`, and tx_busy clears on the same edge.
- A new TXD write is accepted on the same edge tx_busy clears? No: it is accepted only when tx_busy=0 before the edge.
- RX: first low synchronized 2 cycles after the pin falls.
- rx_valid rises ≈9.5·`BAUD_DIV`+3 cycles after the start-bit falling edge, i.e. at the STOP sample.
- `irq_out` follows its inputs with 1-cycle latency.
- `Read_data` has zero-cycle latency, and a clear is visible the cycle after the read.
- Bit counters are `$clog2(BAUD_DIV)` wide and wrap at `BAUD_DIV-1` back to 0.

## Test plan
(Bench uses `BAUD_DIV`=16.)
- TX frame: write 0xA5 to TXD at edge N.
  - `uart_tx` = 0, 1,0,1,0,0,1,0,1, 1, each 16 cycles, starting at N+1.
  - tx_done=1 at N+161. A CON read returns `0x04`, then the next CON read returns `0x00`.
- Busy drop: second TXD write (0x3C) 20 cycles after the first.
  - The frame still carries 0xA5, and a TXD read returns 0xA5.
- RX receive with IRQ: CON=0x2, then drive the frame for 0x5A on `uart_rx`.
  - rx_valid=1 and `irq_out`=1 one cycle later.
  - An RXD read returns 0x5A; `irq_out`=0 two cycles after the read.
- Overrun and framing:
  - Two frames (0x11, 0x22) arrive without a read → RXD=0x22 and CON[5]=1.
  - A frame whose stop bit = 0 → rx_valid unchanged.
- Glitch and decode: a 4-cycle low pulse on `uart_rx` → no reception.
  - A read of 0x40000024 returns 0.
  - A write to 0x40000014 does not alter any register.
- Reset mid-frame: assert `reset`=0 for one cycle at bit 4 of a TX frame.
  - `uart_tx`=1 from the next edge, tx_done=0, and a fresh write transmits correctly.
